// File: rtl/store_merge_unit.sv
// Sub-word store engine: read-modify-write for byte/half stores, direct write for
// full words, misaligned or reserved-size requests reported through err with done.
module store_merge_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  req_i,
  input  logic [1:0]            size_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_wr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int CW    = $clog2(MEM_LATENCY + 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_FULL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    DONE
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [1:0]              size_q;
  logic [OFF-1:0]          lane_q;
  logic [15:0]             wdata_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic                    mem_wr_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;

  logic                    bad_d;
  logic [DATA_WIDTH-1:0]   merged_d;

  always_comb begin
    bad_d = 1'b0;
    if (size_i == SZ_RSVD) begin
      bad_d = 1'b1;
    end else if (size_i == SZ_HALF && addr_i[0]) begin
      bad_d = 1'b1;
    end else if (size_i == SZ_FULL && addr_i[OFF-1:0] != '0) begin
      bad_d = 1'b1;
    end
  end

  // A half store is always even-aligned, so its upper byte sits in lane_q|1.
  always_comb begin
    merged_d = mem_rdata_i;
    for (int l = 0; l < LANES; l++) begin
      if (OFF'(l) == lane_q) begin
        merged_d[8*l +: 8] = wdata_q[7:0];
      end
      if (size_q == SZ_HALF && OFF'(l) == (lane_q | OFF'(1))) begin
        merged_d[8*l +: 8] = wdata_q[15:8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= SZ_BYTE;
      lane_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            mem_addr_q <= {addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            size_q     <= size_i;
            lane_q     <= addr_i[OFF-1:0];
            wdata_q    <= wdata_i[15:0];
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (bad_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (size_i == SZ_FULL) begin
              state_q     <= WRITE;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= wdata_i;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (cnt_q == CW'(MEM_LATENCY - 1)) begin
            state_q <= MERGE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        MERGE: begin
          mem_wdata_q <= merged_d;
          mem_wr_q    <= 1'b1;
          cnt_q       <= '0;
          state_q     <= WRITE;
        end
        WRITE: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit (64-bit words, 3-cycle memory): directed and random
// stores checked against a mask-based memory model, plus reset abort and held req.
module tb_store_merge_unit;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int ML = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    size = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          busy, done, err, memWr;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata, memRdata;

  logic [DW-1:0] memArr [16];
  logic [DW-1:0] pipe [ML];
  logic          preWe = 1'b0;
  logic [3:0]    preIdx = '0;
  logic [DW-1:0] preData = '0;

  logic [DW-1:0] refMem [16];
  int checks = 0;
  int errors = 0;

  store_merge_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(ML)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_i(req), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .busy_o(busy), .done_o(done), .err_o(err), .mem_addr_o(memAddr),
    .mem_wr_o(memWr), .mem_wdata_o(memWdata), .mem_rdata_i(memRdata)
  );

  always #5 clk = ~clk;

  // Memory with ML registered read stages; word index from address bits [6:3].
  always @(posedge clk) begin
    pipe[0] <= memArr[memAddr[6:3]];
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    if (preWe) memArr[preIdx] <= preData;
    else if (memWr) memArr[memAddr[6:3]] <= memWdata;
  end
  assign memRdata = pipe[ML-1];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isErr(input logic [1:0] sz, input logic [AW-1:0] a);
    return (sz == 2'b10) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b11 && a % 8 != 0);
  endfunction

  function automatic logic [63:0] expectWord(input logic [63:0] old, input logic [1:0] sz,
                                             input logic [AW-1:0] a, input logic [63:0] wd);
    int lane = int'(a % 8);
    int nBytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 8;
    logic [63:0] mask = '0;
    for (int b = 0; b < nBytes; b++) mask = mask | (64'hFF << (8 * (lane + b)));
    return (old & ~mask) | ((wd << (8 * lane)) & mask);
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic applyStimulus(input logic [1:0] sz, input logic [AW-1:0] a, input logic [63:0] wd);
    bit expErr = isErr(sz, a);
    int idx = int'((a >> 3) & 15);
    logic [63:0] expWord = expectWord(refMem[idx], sz, a, wd);
    logic [AW-1:0] expAddr = a & ~32'h7;
    int expDone = expErr ? 1 : (sz == 2'b11) ? 2 : ML + 3;
    int expWr = (sz == 2'b11) ? 1 : ML + 2;
    int cyc = 1, wrCnt = 0, wrCyc = 0, doneCyc = 0;
    logic gotErr = 1'b0;
    logic [AW-1:0] gotAddr = '0;
    logic [DW-1:0] gotData = '0;
    req = 1'b1; size = sz; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; size = 2'($urandom); addr = $urandom; wdata = {$urandom, $urandom};
    checkOutput("busyCycle1", busy, 1);
    while (cyc <= 20 && doneCyc == 0) begin
      if (memWr) begin wrCnt++; wrCyc = cyc; gotAddr = memAddr; gotData = memWdata; end
      if (done) begin doneCyc = cyc; gotErr = err; end
      else begin @(negedge clk); cyc++; end
    end
    checkOutput("doneCycle", doneCyc, expDone);
    checkOutput("err", gotErr, expErr);
    checkOutput("wrCount", wrCnt, expErr ? 0 : 1);
    if (!expErr) begin
      checkOutput("wrCycle", wrCyc, expWr);
      checkOutput("wrAddr", gotAddr, expAddr);
      checkOutput("wrData", gotData, expWord);
      refMem[idx] = expWord;
    end
    @(negedge clk);
    checkOutput("busyAfterDone", busy, 0);
    checkOutput("addrHold", memAddr, expAddr);
    if (!expErr) checkOutput("dataHold", memWdata, expWord);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    checkOutput("idleWait", busy, 0);
  endtask

  initial begin
    int wrCnt, doneCnt, gapBad, dataBad, lastWr;
    logic [63:0] heldWd;
    // Reset state and memory preload.
    #2;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstWr", memWr, 0);
    checkOutput("rstAddr", memAddr, 0);
    checkOutput("rstData", memWdata, 0);
    for (int i = 0; i < 16; i++) refMem[i] = {$urandom, $urandom};
    refMem[0] = 64'h0011223344556677;
    refMem[1] = 64'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      preWe = 1'b1; preIdx = 4'(i); preData = refMem[i];
    end
    @(negedge clk);
    preWe = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(2'b00, 32'h10F, 64'h5A);
    applyStimulus(2'b00, 32'h102, 64'hFFFF_FFEE);
    applyStimulus(2'b01, 32'h106, 64'h1234_BEEF);
    applyStimulus(2'b01, 32'h100, 64'h2233);
    applyStimulus(2'b11, 32'h110, 64'h0123_4567_89AB_CDEF);
    applyStimulus(2'b01, 32'h101, 64'h2233);
    applyStimulus(2'b10, 32'h100, 64'h1);
    applyStimulus(2'b11, 32'h104, 64'h1);

    // Reset during READ abandons the store.
    req = 1'b1; size = 2'b00; addr = 32'h10F; wdata = 64'hA5;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortErr", err, 0);
    checkOutput("abortWr", memWr, 0);
    checkOutput("abortAddr", memAddr, 0);
    checkOutput("abortData", memWdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wrCnt = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (memWr) wrCnt++; end
    checkOutput("abortNoWrite", wrCnt, 0);
    applyStimulus(2'b00, 32'h10F, 64'h77);

    // req held high with full-word stores: one acceptance every 3 cycles.
    heldWd = {$urandom, $urandom};
    req = 1'b1; size = 2'b11; addr = 32'h118; wdata = heldWd;
    wrCnt = 0; doneCnt = 0; gapBad = 0; dataBad = 0; lastWr = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (memWr) begin
        wrCnt++;
        if (lastWr != 0 && cyc - lastWr != 3) gapBad++;
        if (memWdata !== heldWd || memAddr !== 32'h118) dataBad++;
        lastWr = cyc;
      end
      if (done) begin doneCnt++; if (err) dataBad++; end
    end
    req = 1'b0;
    checkOutput("heldWrites", wrCnt, 10);
    checkOutput("heldDones", doneCnt, 10);
    checkOutput("heldGap", gapBad, 0);
    checkOutput("heldData", dataBad, 0);
    refMem[3] = heldWd;
    waitIdle();

    for (int n = 0; n < 40; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), 32'h100 + 32'($urandom_range(0, 127)),
                    {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
